tile_rect_plotter: RTL and testbench

//  Parametrised pixel sequencer that draws, erases or scrolls one falling-tile rectangle in a lane.
//  It sits between the game FSM and the VGA adapter.
//  It emits one pixel per clock on VGA_X/VGA_Y/VGA_COLOR/plot, with a start/busy/done handshake.
//  It generalises the fixed display path to N lanes, arbitrary tile size, bottom-edge clipping
//  and an incremental scroll mode.

---
 rtl/tile_rect_plotter.sv | 218 +++++++++++++++++++++
 tb/tb_tile_rect_plotter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rect_plotter.sv
// Pixel sequencer that draws, erases or scrolls one falling-tile rectangle in a lane.
// It emits one registered pixel per clock to the VGA adapter and uses a start/busy/done handshake.
module tile_rect_plotter #(
  parameter int                   LANES      = 4,
  parameter int                   LANE_W     = 40,
  parameter int                   TILE_H     = 30,
  parameter int                   SCREEN_H   = 120,
  parameter int                   XW         = 8,
  parameter int                   YW         = 7,
  parameter int                   COLOR_W    = 3,
  parameter logic [COLOR_W-1:0]   TILE_COLOR = 3'b000,
  parameter logic [COLOR_W-1:0]   BG_COLOR   = 3'b111,
  localparam int                  LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [LW-1:0]      lane,
  input  logic [YW-1:0]      y_top,
  input  logic [YW-1:0]      dy,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [XW-1:0]      VGA_X,
  output logic [YW-1:0]      VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot
);

  localparam int CW = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  // Row arithmetic is two bits wider than YW so y_top+dy+TILE_H never wraps.
  localparam int EW = YW + 2;
  localparam logic [EW-1:0] TH       = EW'(TILE_H);
  localparam logic [EW-1:0] SH       = EW'(SCREEN_H);
  localparam logic [EW-1:0] ONE_ROW  = EW'(1);
  localparam logic [CW-1:0] LAST_COL = CW'(LANE_W - 1);
  localparam logic [CW-1:0] ONE_COL  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLOT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [YW-1:0]      yTop_q, yTop_d;
  logic [YW-1:0]      dy_q, dy_d;
  logic [EW-1:0]      aHi_q, aHi_d;
  logic [EW-1:0]      bLo_q, bLo_d;
  logic [EW-1:0]      bHi_q, bHi_d;
  logic               bEn_q, bEn_d;
  logic               rej_q, rej_d;
  logic               phaseB_q, phaseB_d;
  logic [EW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [XW-1:0]      xBase_q, xBase_d;
  logic [COLOR_W-1:0] aColor_q, aColor_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               plot_q, plot_d;
  logic [XW-1:0]      vgaX_q, vgaX_d;
  logic [YW-1:0]      vgaY_q, vgaY_d;
  logic [COLOR_W-1:0] vgaColor_q, vgaColor_d;

  logic [EW-1:0] yTopE, dyE, aHiRaw, aHiC, bLoC, bHiRaw, bHiC, curHi;
  logic          isScroll, aEnC, bEnC, rejC;

  // Phase A erases the uncovered top (or the whole tile), phase B draws the newly covered bottom.
  assign yTopE    = EW'(yTop_q);
  assign dyE      = EW'(dy_q);
  assign isScroll = (mode_q == 2'b10);
  assign aHiRaw   = yTopE + (isScroll ? ((dyE < TH) ? dyE : TH) : TH);
  assign aHiC     = (aHiRaw < SH) ? aHiRaw : SH;
  assign aEnC     = (yTopE < aHiC);
  assign bLoC     = (TH > dyE) ? (yTopE + TH) : (yTopE + dyE);
  assign bHiRaw   = yTopE + dyE + TH;
  assign bHiC     = (bHiRaw < SH) ? bHiRaw : SH;
  assign bEnC     = isScroll && (bLoC < bHiC);
  assign rejC     = ({1'b0, lane_q} >= (LW+1)'(LANES)) || (mode_q == 2'b11);
  assign curHi    = phaseB_q ? bHi_q : aHi_q;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      lane_q     <= '0;
      yTop_q     <= '0;
      dy_q       <= '0;
      aHi_q      <= '0;
      bLo_q      <= '0;
      bHi_q      <= '0;
      bEn_q      <= 1'b0;
      rej_q      <= 1'b0;
      phaseB_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      xBase_q    <= '0;
      aColor_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      plot_q     <= 1'b0;
      vgaX_q     <= '0;
      vgaY_q     <= '0;
      vgaColor_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lane_q     <= lane_d;
      yTop_q     <= yTop_d;
      dy_q       <= dy_d;
      aHi_q      <= aHi_d;
      bLo_q      <= bLo_d;
      bHi_q      <= bHi_d;
      bEn_q      <= bEn_d;
      rej_q      <= rej_d;
      phaseB_q   <= phaseB_d;
      row_q      <= row_d;
      col_q      <= col_d;
      xBase_q    <= xBase_d;
      aColor_q   <= aColor_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      plot_q     <= plot_d;
      vgaX_q     <= vgaX_d;
      vgaY_q     <= vgaY_d;
      vgaColor_q <= vgaColor_d;
    end
  end

  // Handshake outputs trail the state by one cycle, matching the registered pixel path.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lane_d     = lane_q;
    yTop_d     = yTop_q;
    dy_d       = dy_q;
    aHi_d      = aHi_q;
    bLo_d      = bLo_q;
    bHi_d      = bHi_q;
    bEn_d      = bEn_q;
    rej_d      = rej_q;
    phaseB_d   = phaseB_q;
    row_d      = row_q;
    col_d      = col_q;
    xBase_d    = xBase_q;
    aColor_d   = aColor_q;
    busy_d     = (state_q == S_LOAD) || (state_q == S_PLOT);
    done_d     = (state_q == S_DONE);
    err_d      = (state_q == S_DONE) && rej_q;
    plot_d     = 1'b0;
    vgaX_d     = vgaX_q;
    vgaY_d     = vgaY_q;
    vgaColor_d = vgaColor_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          lane_d  = lane;
          yTop_d  = y_top;
          dy_d    = dy;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rej_d    = rejC;
        aHi_d    = aHiC;
        bLo_d    = bLoC;
        bHi_d    = bHiC;
        bEn_d    = bEnC;
        aColor_d = (mode_q == 2'b00) ? TILE_COLOR : BG_COLOR;
        xBase_d  = XW'(lane_q * LANE_W);
        col_d    = '0;
        phaseB_d = !aEnC;
        row_d    = aEnC ? yTopE : bLoC;
        if (rejC || (!aEnC && !bEnC)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PLOT;
        end
      end
      S_PLOT: begin
        plot_d     = 1'b1;
        vgaX_d     = xBase_q + XW'(col_q);
        vgaY_d     = row_q[YW-1:0];
        vgaColor_d = phaseB_q ? TILE_COLOR : aColor_q;
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + ONE_ROW;
          if ((row_q + ONE_ROW) == curHi) begin
            if (!phaseB_q && bEn_q) begin
              phaseB_d = 1'b1;
              row_d    = bLo_q;
            end else begin
              state_d = S_DONE;
            end
          end
        end else begin
          col_d = col_q + ONE_COL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign plot      = plot_q;
  assign VGA_X     = vgaX_q;
  assign VGA_Y     = vgaY_q;
  assign VGA_COLOR = vgaColor_q;

endmodule

// File: tb/tb_tile_rect_plotter.sv
// Self-checking bench for tile_rect_plotter: scenario tasks plus randomized commands
// checked against a row/column reference model of the drawing rules.
module tb_tile_rect_plotter;

  localparam int LANE_W   = 40;
  localparam int TILE_H   = 30;
  localparam int SCREEN_H = 120;
  localparam int NLANES   = 4;
  localparam logic [2:0] TILE_C = 3'b000;
  localparam logic [2:0] BG_C   = 3'b111;

  logic       clk, rstN, start, start3;
  logic [1:0] mode, lane, lane3;
  logic [6:0] yTop, dy;
  logic       busy, done, err, plot;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColor;
  logic       busy3, done3, err3, plot3;
  logic [7:0] vgaX3;
  logic [6:0] vgaY3;
  logic [2:0] vgaColor3;

  int nChecks = 0;
  int nPass   = 0;

  logic [17:0] obsQ[$];
  logic [17:0] expQ[$];
  int          firstPlot, doneCyc, errStray;
  logic        errAtDone, busyAtDone;
  bit          expErr;

  tile_rect_plotter dut (
    .CLOCK_50(clk), .Resetn(rstN), .start(start), .mode(mode), .lane(lane),
    .y_top(yTop), .dy(dy), .busy(busy), .done(done), .err(err),
    .VGA_X(vgaX), .VGA_Y(vgaY), .VGA_COLOR(vgaColor), .plot(plot)
  );

  // Three-lane instance so that an out-of-range lane code is representable.
  tile_rect_plotter #(.LANES(3)) dut3 (
    .CLOCK_50(clk), .Resetn(rstN), .start(start3), .mode(mode), .lane(lane3),
    .y_top(yTop), .dy(dy), .busy(busy3), .done(done3), .err(err3),
    .VGA_X(vgaX3), .VGA_Y(vgaY3), .VGA_COLOR(vgaColor3), .plot(plot3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pixels for rows first..last of a lane, clipped at the screen bottom.
  function automatic void addRows(int first, int last, int l, logic [2:0] col);
    for (int y = first; y <= last && y < SCREEN_H; y++)
      for (int c = 0; c < LANE_W; c++)
        expQ.push_back({8'(l * LANE_W + c), 7'(y), col});
  endfunction

  function automatic void buildModel(int m, int l, int yt, int d);
    expQ.delete();
    expErr = (l >= NLANES) || (m == 3);
    if (expErr) return;
    if (m == 0) addRows(yt, yt + TILE_H - 1, l, TILE_C);
    else if (m == 1) addRows(yt, yt + TILE_H - 1, l, BG_C);
    else begin
      addRows(yt, yt + ((d < TILE_H) ? d : TILE_H) - 1, l, BG_C);
      addRows((yt + TILE_H > yt + d) ? yt + TILE_H : yt + d, yt + d + TILE_H - 1, l, TILE_C);
    end
  endfunction

  // Issues one command (start sampled at edge 0) and records everything seen until done.
  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] l,
                               input logic [6:0] yt, input logic [6:0] d, input bit poke);
    obsQ.delete();
    firstPlot = -1; doneCyc = -1; errStray = 0; errAtDone = 1'b0; busyAtDone = 1'b1;
    @(negedge clk);
    start = 1'b1; mode = m; lane = l; yTop = yt; dy = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (poke && cyc == 3) begin start = 1'b1; mode = 2'b01; lane = 2'b00; yTop = 7'd0; end
      if (poke && cyc == 10) start = 1'b0;
      if (plot) begin
        obsQ.push_back({vgaX, vgaY, vgaColor});
        if (firstPlot < 0) firstPlot = cyc;
      end
      if (err && !done) errStray++;
      if (done) begin
        doneCyc = cyc; errAtDone = err; busyAtDone = busy;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    start = 1'b0; start3 = 1'b0; mode = 2'b00; lane = 2'd1; lane3 = 2'd0; yTop = 7'd10; dy = 7'd0;
    rstN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); start = i[0];
      @(posedge clk); #1;
      if ({busy, done, err, plot, vgaX, vgaY, vgaColor} !== '0) bad++;
    end
    nChecks++;
    if (bad !== 0) $display("[TB] FAIL reset_outputs: %0d cycles nonzero, required 0", bad);
    else nPass++;
    @(negedge clk); start = 1'b0; rstN = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || plot || done) bad++;
    end
    nChecks++;
    if (bad !== 0) $display("[TB] FAIL reset_idle: %0d active cycles after release, required 0", bad);
    else nPass++;
  endtask

  task automatic test_draw();
    int tm[5] = '{0, 0, 0, 1, 0};
    int tl[5] = '{1, 3, 2, 0, 0};
    int ty[5] = '{10, 100, 120, 5, 119};
    for (int t = 0; t < 5; t++) begin
      int bad = 0;
      buildModel(tm[t], tl[t], ty[t], 0);
      applyStimulus(2'(tm[t]), 2'(tl[t]), 7'(ty[t]), 7'd0, 1'b0);
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) if (obsQ[i] !== expQ[i]) bad++;
      nChecks++;
      if (obsQ.size() !== expQ.size()) $display("[TB] FAIL draw%0d_count: got %0d plots, required %0d", t, obsQ.size(), expQ.size());
      else nPass++;
      nChecks++;
      if (bad !== 0) $display("[TB] FAIL draw%0d_pixels: %0d wrong pixels, required 0", t, bad);
      else nPass++;
      nChecks++;
      if (firstPlot !== ((expQ.size() > 0) ? 2 : -1)) $display("[TB] FAIL draw%0d_first: first plot cycle %0d", t, firstPlot);
      else nPass++;
      nChecks++;
      if (doneCyc !== expQ.size() + 2) $display("[TB] FAIL draw%0d_done: done cycle %0d, required %0d", t, doneCyc, expQ.size() + 2);
      else nPass++;
      nChecks++;
      if ({errAtDone, busyAtDone} !== 2'b00) $display("[TB] FAIL draw%0d_flags: err=%0b busy=%0b at done, required 0 0", t, errAtDone, busyAtDone);
      else nPass++;
    end
  endtask

  task automatic test_scroll();
    int tl[4] = '{0, 0, 2, 1};
    int ty[4] = '{20, 20, 90, 10};
    int td[4] = '{4, 40, 20, 0};
    for (int t = 0; t < 4; t++) begin
      int bad = 0;
      buildModel(2, tl[t], ty[t], td[t]);
      applyStimulus(2'b10, 2'(tl[t]), 7'(ty[t]), 7'(td[t]), 1'b0);
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) if (obsQ[i] !== expQ[i]) bad++;
      nChecks++;
      if (obsQ.size() !== expQ.size()) $display("[TB] FAIL scroll%0d_count: got %0d plots, required %0d", t, obsQ.size(), expQ.size());
      else nPass++;
      nChecks++;
      if (bad !== 0) $display("[TB] FAIL scroll%0d_pixels: %0d wrong pixels, required 0", t, bad);
      else nPass++;
      nChecks++;
      if (doneCyc !== expQ.size() + 2) $display("[TB] FAIL scroll%0d_done: done cycle %0d, required %0d", t, doneCyc, expQ.size() + 2);
      else nPass++;
    end
  endtask

  task automatic test_busy_ignore();
    int bad = 0;
    int extra = 0;
    buildModel(0, 2, 40, 0);
    applyStimulus(2'b00, 2'd2, 7'd40, 7'd0, 1'b1);
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) if (obsQ[i] !== expQ[i]) bad++;
    nChecks++;
    if (obsQ.size() !== expQ.size() || bad !== 0) $display("[TB] FAIL busy_pixels: %0d plots with %0d wrong, required %0d with 0 wrong", obsQ.size(), bad, expQ.size());
    else nPass++;
    nChecks++;
    if (doneCyc !== expQ.size() + 2) $display("[TB] FAIL busy_done: done cycle %0d, required %0d", doneCyc, expQ.size() + 2);
    else nPass++;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || plot) extra++;
    end
    nChecks++;
    if (extra !== 0) $display("[TB] FAIL busy_no_restart: %0d active cycles after done, required 0", extra);
    else nPass++;
  endtask

  task automatic test_reject();
    logic [1:0] tl3[2] = '{2'd3, 2'd2};
    int         want3[2] = '{0, 400};
    applyStimulus(2'b11, 2'd1, 7'd10, 7'd4, 1'b0);
    nChecks++;
    if (obsQ.size() !== 0 || doneCyc !== 2) $display("[TB] FAIL reject_mode: %0d plots, done cycle %0d, required 0 plots, cycle 2", obsQ.size(), doneCyc);
    else nPass++;
    nChecks++;
    if (errAtDone !== 1'b1 || errStray !== 0) $display("[TB] FAIL reject_err: err at done %0b, stray err %0d, required 1 and 0", errAtDone, errStray);
    else nPass++;
    for (int t = 0; t < 2; t++) begin
      int nPlot = 0;
      int dCyc = -1;
      logic e = 1'b0;
      @(negedge clk);
      start3 = 1'b1; lane3 = tl3[t]; mode = 2'b00; yTop = 7'd110; dy = 7'd0;
      @(posedge clk); #1;
      start3 = 1'b0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
        if (plot3) nPlot++;
        if (done3) begin dCyc = cyc; e = err3; break; end
        @(posedge clk); #1;
      end
      nChecks++;
      if (nPlot !== want3[t] || dCyc !== want3[t] + 2 || e !== (t == 0)) $display("[TB] FAIL lanes3_%0d: %0d plots, done %0d, err %0b, required %0d plots, done %0d", t, nPlot, dCyc, e, want3[t], want3[t] + 2);
      else nPass++;
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    int sawDone = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; lane = 2'd1; yTop = 7'd10; dy = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    nChecks++;
    if ({plot, busy} !== 2'b11) $display("[TB] FAIL mid_active: plot=%0b busy=%0b, required 1 1", plot, busy);
    else nPass++;
    #1 rstN = 1'b0;
    #1;
    nChecks++;
    if ({plot, busy, done} !== 3'b000) $display("[TB] FAIL mid_reset_drop: plot=%0b busy=%0b done=%0b, required 0 0 0", plot, busy, done);
    else nPass++;
    @(negedge clk); rstN = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) sawDone++;
      if (plot || busy) bad++;
    end
    nChecks++;
    if (sawDone !== 0 || bad !== 0) $display("[TB] FAIL mid_abandon: %0d done pulses, %0d active cycles, required 0", sawDone, bad);
    else nPass++;
    bad = 0;
    buildModel(0, 1, 10, 0);
    applyStimulus(2'b00, 2'd1, 7'd10, 7'd0, 1'b0);
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) if (obsQ[i] !== expQ[i]) bad++;
    nChecks++;
    if (obsQ.size() !== expQ.size() || bad !== 0 || doneCyc !== 1202) $display("[TB] FAIL mid_recover: %0d plots, %0d wrong, done %0d, required %0d, 0, 1202", obsQ.size(), bad, doneCyc, expQ.size());
    else nPass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int bad = 0;
      int m  = $urandom_range(0, 3);
      int l  = $urandom_range(0, 3);
      int yt = $urandom_range(0, 127);
      int d  = $urandom_range(0, 127);
      if (t < 3) m = 2;
      buildModel(m, l, yt, d);
      applyStimulus(2'(m), 2'(l), 7'(yt), 7'(d), 1'b0);
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) if (obsQ[i] !== expQ[i]) bad++;
      nChecks++;
      if (obsQ.size() !== expQ.size() || bad !== 0) $display("[TB] FAIL rand%0d_pixels (m=%0d l=%0d y=%0d dy=%0d): %0d plots, %0d wrong, required %0d", t, m, l, yt, d, obsQ.size(), bad, expQ.size());
      else nPass++;
      nChecks++;
      if (doneCyc !== expQ.size() + 2 || errAtDone !== expErr) $display("[TB] FAIL rand%0d_done: cycle %0d err %0b, required %0d err %0b", t, doneCyc, errAtDone, expQ.size() + 2, expErr);
      else nPass++;
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_scroll();
    test_busy_ignore();
    test_reject();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
